muacm_loopback: RTL
===================

# muacm_loopback

Parametrised loopback engine for the muacm CDC-ACM core, running entirely in the clk_usb domain. It takes the host-to-device byte stream (muacm out_*), buffers it in a DEPTH-entry FIFO and returns it on the device-to-host stream (muacm in_*). It also generates the in_flush_now / in_flush_time controls. It replaces the fixed 4-deep echo FIFO with three framing modes: raw echo, packet store-and-forward, and line store-and-forward.

## Interface

Parameters:
- DEPTH, 64: FIFO entries. Must be a power of 2 and at least 4.
- MODE, 0: framing mode. 0 = raw echo; 1 = packet (segment ends on rx_last); 2 = line (segment ends on rx_last or a byte equal to LINE_CHAR).
- LINE_CHAR, 8'h0A: line terminator, used in MODE 2 only.

Ports:
- clk_usb  in  1  USB clock, 48 MHz.
- rst_usb  in  1  Reset: asynchronous, active-high.
- rx_data  in  8  Byte from muacm out_data.
- rx_last  in  1  End-of-USB-packet marker from muacm out_last.
- rx_valid  in  1  Byte valid.
- rx_ready  out  1  FIFO can accept a byte.
- tx_data  out  8  Byte to muacm in_data.
- tx_last  out  1  Byte closes a segment.
- tx_valid  out  1  Byte available.
- tx_ready  in  1  muacm accepts the byte.
- tx_flush_now  out  1  One-cycle flush request.
- tx_flush_time  out  1  Timeout-flush enable.
- level  out  $clog2(DEPTH)+1  Bytes currently stored, committed or not.
- seg_cnt  out  16  Number of committed segments; wraps modulo 2^16.

## Operation

Storage and pointers:
- Each FIFO entry holds 9 bits: the data byte plus a boundary flag.
- Pointers are wr_ptr, cm_ptr (commit) and rd_ptr, each $clog2(DEPTH)+1 bits wide and wrapping naturally.
- level = wr_ptr − rd_ptr.
- The readable count is cm_ptr − rd_ptr.

Handshakes:
- Write: a byte is written when rx_valid & rx_ready. rx_ready = (level != DEPTH).
- Read: a byte is popped when tx_valid & tx_ready. tx_valid = (cm_ptr != rd_ptr).
- tx_data and tx_last show the entry at rd_ptr. tx_last is that entry's boundary flag.

Boundary flag on each written byte:
- MODE 0: rx_last.
- MODE 1: rx_last, or this write fills the FIFO (level becomes DEPTH).
- MODE 2: rx_last, or rx_data == LINE_CHAR, or this write fills the FIFO.

Commit rule:
- MODE 0: cm_ptr follows wr_ptr on every write.
- MODE 1/2: cm_ptr jumps to wr_ptr+1 on a write whose boundary flag is 1. Otherwise it is unchanged.
- Forced commit on full guarantees forward progress for segments longer than DEPTH. Such a segment is emitted as DEPTH-byte chunks, each with tx_last=1 on its final byte.

seg_cnt:
- Increments by 1 on every write with boundary flag = 1, in any mode.

Flush outputs:
- tx_flush_now is a registered one-cycle pulse in the cycle after a popped byte with tx_last=1. It is 0 in MODE 0.
- tx_flush_time = 1 in MODE 0 and 0 in MODE 1/2. It is a static tie, not registered.

Simultaneous events:
- A write and a read in the same cycle are both performed; level is unchanged.
- A commit and a pop of the last readable byte in the same cycle leave tx_valid = 1 on the next cycle.

Reset:
- Reset clears all pointers and seg_cnt. Uncommitted data is discarded.
- Reset mid-segment leaves no partial segment visible afterwards.

## Timing

- Reset values: rx_ready=1, tx_valid=0, tx_last=0, tx_flush_now=0, level=0, seg_cnt=0. tx_data is don't-care while tx_valid=0. tx_flush_time is held at its static value.
- Latency: a byte written at edge N, with a flag that commits it, has tx_valid=1 from edge N+1. Data path latency is 1 cycle. A registered read port or prefetch stage is permitted provided this latency holds.
- Throughput: 1 byte per cycle sustained in each direction.
- rx_ready depends only on registered state, never combinationally on tx_ready.
- tx_valid, tx_data and tx_last are stable while tx_valid=1 and tx_ready=0. They change only after a pop or a new commit.
- level and seg_cnt update on the edge of the write or read that changes them.

## Test plan

- MODE 0, DEPTH=4: stream 0x00..0x3F with tx_ready=1.
  - Required: identical order, byte k out at cycle k+1.
  - Required: tx_flush_time=1, tx_flush_now never asserted.
- MODE 0, full FIFO: tx_ready=0, write 5 bytes.
  - Required: rx_ready drops after the 4th byte and level=4.
  - Then release tx_ready: required bytes 1–4 out, then the 5th accepted.
- MODE 1: write 0x11,0x22,0x33 with rx_last on 0x33, holding tx_ready=1.
  - Required: tx_valid stays 0 until the cycle after 0x33 is written.
  - Required: tx_last=1 on 0x33, one tx_flush_now pulse, seg_cnt=1.
- MODE 2, LINE_CHAR=0x0A: write "ab\ncd" with no rx_last.
  - Required: "ab\n" emitted with tx_last on 0x0A, and seg_cnt=1.
  - Required: "cd" held with level=2, tx_valid=0.
- MODE 1, DEPTH=4: 10-byte packet, rx_last on the 10th byte.
  - Required: three segments of 4, 4 and 2 bytes, each ending tx_last=1, and seg_cnt=3.
  - Required: no deadlock.
- Assert rst_usb mid-packet in MODE 1 with 3 bytes uncommitted.
  - Required: level=0, tx_valid=0 and seg_cnt=0 immediately.
  - Required: the next packet is echoed intact.

Source files
------------

// File: rtl/muacm_loopback.sv
// Loopback engine for the muacm CDC-ACM core: buffers the host-to-device byte stream
// and returns it to the host, framed as raw echo, packets or lines.
module muacm_loopback #(
   parameter int          DEPTH     = 64,
   parameter int          MODE      = 0,
   parameter logic [7:0]  LINE_CHAR = 8'h0A
) (
   input  logic                     clk_usb,
   input  logic                     rst_usb,
   input  logic [7:0]               rx_data,
   input  logic                     rx_last,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_last,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     tx_flush_now,
   output logic                     tx_flush_time,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              seg_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] FULL    = PW'(DEPTH);
   localparam logic [PW-1:0] FULL_M1 = PW'(DEPTH - 1);

   // Handshakes: a byte moves on a side exactly in the cycle where valid and ready are both high.
   logic [8:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_cm_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [15:0]   r_seg_cnt;
   logic          r_flush_now;

   logic [PW-1:0] w_level;
   logic [PW-1:0] w_wr_ptr_nx;
   logic [8:0]    w_head;
   logic          w_wr;
   logic          w_rd;
   logic          w_fill;
   logic          w_flag;

   assign w_level     = r_wr_ptr - r_rd_ptr;
   assign w_wr_ptr_nx = r_wr_ptr + PW'(1);
   assign rx_ready    = (w_level != FULL);
   assign tx_valid    = (r_cm_ptr != r_rd_ptr);
   assign w_wr        = rx_valid & rx_ready;
   assign w_rd        = tx_valid & tx_ready;
   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
   assign tx_data     = w_head[7:0];
   assign tx_last     = tx_valid & w_head[8];

   // A write that leaves the FIFO full must close the segment, or a long one would deadlock.
   assign w_fill = (w_level == FULL_M1) & ~w_rd;

   always_comb begin
      w_flag = rx_last;
      if (MODE == 1) begin
         w_flag = rx_last | w_fill;
      end else if (MODE == 2) begin
         w_flag = rx_last | w_fill | (rx_data == LINE_CHAR);
      end
   end

   always_ff @(posedge clk_usb) begin
      if (w_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {w_flag, rx_data};
      end
   end

   always_ff @(posedge clk_usb or posedge rst_usb) begin
      if (rst_usb) begin
         r_wr_ptr    <= '0;
         r_cm_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_seg_cnt   <= '0;
         r_flush_now <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= w_wr_ptr_nx;
            if ((MODE == 0) || w_flag) begin
               r_cm_ptr <= w_wr_ptr_nx;
            end
            if (w_flag) begin
               r_seg_cnt <= r_seg_cnt + 16'd1;
            end
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_flush_now <= (MODE != 0) && w_rd && w_head[8];
      end
   end

   assign tx_flush_now  = r_flush_now;
   assign tx_flush_time = (MODE == 0);
   assign level         = w_level;
   assign seg_cnt       = r_seg_cnt;

endmodule
